// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - RAW hazard stall/issue/flush control over a shadow valid/we/rd pipeline
// Optional FWD_HAZARD_EN: entries >= FWD_MIN forward to decode instead of stalling it.
module pipe_hazard_ctrl #(
  parameter int DEPTH       = 4,
  parameter int REG_AW      = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int RF_BYPASS   = 1,
  parameter int CNT_W       = 32
`ifdef FWD_HAZARD_EN
  ,
  parameter int FWD_MIN     = 1
`endif
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs1,
  input  logic [REG_AW-1:0]          id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_rd_we,
  input  logic                       ext_stall,
  input  logic                       flush_req,
  output logic                       stall_id,
  output logic                       issue,
  output logic [DEPTH-1:0]           stage_valid,
  output logic                       wb_valid,
  output logic [REG_AW-1:0]          wb_rd,
`ifdef FWD_HAZARD_EN
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs2,
`endif
  output logic [CNT_W-1:0]           stall_cnt
);

  // A write-through register file makes the writeback entry invisible to hazard checks.
  localparam int HZ_LAST = (RF_BYPASS != 0) ? DEPTH - 2 : DEPTH - 1;
`ifdef FWD_HAZARD_EN
  localparam int SEL_W = $clog2(DEPTH + 1);
`endif

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  we_q;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic              hazard;
  logic              cnt_en;

  always_comb begin
    hazard = 1'b0;
`ifdef FWD_HAZARD_EN
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    // Walk oldest to youngest so the youngest matching producer wins the select.
    for (int i = HZ_LAST; i >= 0; i--) begin
      if (valid_q[i] && we_q[i]) begin
        if (i >= FWD_MIN) begin
          if (id_rs1_used && id_rs1 != '0 && rd_q[i] == id_rs1) fwd_sel_rs1 = SEL_W'(i + 1);
          if (id_rs2_used && id_rs2 != '0 && rd_q[i] == id_rs2) fwd_sel_rs2 = SEL_W'(i + 1);
        end else if ((id_rs1_used && id_rs1 != '0 && rd_q[i] == id_rs1) ||
                     (id_rs2_used && id_rs2 != '0 && rd_q[i] == id_rs2)) begin
          hazard = 1'b1;
        end
      end
    end
`else
    for (int i = 0; i <= HZ_LAST; i++) begin
      if (valid_q[i] && we_q[i] &&
          ((id_rs1_used && id_rs1 != '0 && rd_q[i] == id_rs1) ||
           (id_rs2_used && id_rs2 != '0 && rd_q[i] == id_rs2))) begin
        hazard = 1'b1;
      end
    end
`endif
  end

  assign issue       = id_valid & ~hazard & ~ext_stall & ~flush_req;
  assign stall_id    = ext_stall | (id_valid & hazard & ~flush_req);
  assign cnt_en      = id_valid & hazard & ~ext_stall & ~flush_req;
  assign stage_valid = valid_q;
  assign wb_valid    = valid_q[DEPTH-1] & we_q[DEPTH-1];
  assign wb_rd       = rd_q[DEPTH-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q   <= '0;
      we_q      <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      if (!ext_stall) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          valid_q[i] <= valid_q[i-1];
          we_q[i]    <= we_q[i-1];
          rd_q[i]    <= rd_q[i-1];
        end
        valid_q[0] <= issue;
        we_q[0]    <= issue & id_rd_we & (id_rd != '0);
        rd_q[0]    <= issue ? id_rd : '0;
      end
      // Squash the youngest entries after the shift/hold above has been decided.
      if (flush_req) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) valid_q[i] <= 1'b0;
      end
      if (cnt_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control block for the RV32I core: tracks in-flight destination registers in a shadow valid/rd pipeline behind decode.
- Detects RAW hazards, generates decode stall and issue, applies branch/jump flushes, and counts hazard stalls.
- Sits beside Decode; supersedes the fixed, hazard-unaware Ps2..Ps6 chain with a depth-generic controller.

Parameters:
- DEPTH, 4, number of shadow entries after decode; entry 0 = execute, entry DEPTH-1 = writeback.
- REG_AW, 5, register address width.
- FLUSH_DEPTH, 1, number of youngest entries invalidated by a flush (1..DEPTH-1).
- RF_BYPASS, 1, 1 = register file is write-through, so entry DEPTH-1 never causes a hazard.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  REG_AW  decode source 1
- id_rs2  in  REG_AW  decode source 2
- id_rs1_used  in  1  rs1 read by the instruction
- id_rs2_used  in  1  rs2 read by the instruction
- id_rd  in  REG_AW  decode destination
- id_rd_we  in  1  instruction writes rd
- ext_stall  in  1  memory not ready; freeze whole pipeline
- flush_req  in  1  taken branch/jump resolved in entry FLUSH_DEPTH-1
- stall_id  out  1  hold fetch and decode this cycle
- issue  out  1  decode instruction enters entry 0 at this edge
- stage_valid  out  DEPTH  valid bit per entry
- wb_valid  out  1  entry DEPTH-1 valid and writes a register
- wb_rd  out  REG_AW  entry DEPTH-1 destination
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset, async on rstn low, including mid-operation: all entries invalid, stall_cnt=0, wb_valid=0, wb_rd=0. Outputs are valid combinationally from the first cycle after release.
- Entry state: valid, we, rd. we is forced to 0 when rd=0.
- Hazard, combinational: any entry i that is valid, has we, and whose rd equals a used rs.
  - With RF_BYPASS=1, i ranges over 0..DEPTH-2.
  - With RF_BYPASS=0, i ranges over 0..DEPTH-1.
  - rs=x0 never hazards.
- Handshake:
  - issue = id_valid & !hazard & !ext_stall & !flush_req.
  - stall_id = ext_stall | (id_valid & hazard & !flush_req).
- Advance, on each clk edge with ext_stall=0:
  - entry[i] <= entry[i-1].
  - entry[0] <= issue ? {1,id_rd_we,id_rd} : bubble.
  - Latency: decode to writeback entry is DEPTH cycles.
- ext_stall=1: no entry moves and no issue. stall_cnt is not incremented.
- Flush:
  - On an edge with flush_req=1, entries 0..FLUSH_DEPTH-1 are invalid after the edge.
  - Older entries advance normally, or hold if ext_stall=1.
  - The decode instruction is discarded (issue=0). Fetch/decode squash is owned by the fetch logic.
  - flush_req and hazard together: flush wins, no stall.
- wb_valid = entry[DEPTH-1].valid & we. wb_rd = entry[DEPTH-1].rd, with no extra register stage.
- stall_cnt: increments on each edge with id_valid & hazard & !ext_stall & !flush_req. Saturates at all-ones and never wraps.
- Simultaneous match of both sources: a single stall. Multiple matching entries: stall until all of them clear.

Optional Feature:
- Macro FWD_HAZARD_EN.
- When defined:
  - Adds parameter FWD_MIN (default 1) and outputs fwd_sel_rs1 and fwd_sel_rs2, width $clog2(DEPTH+1).
  - A match in entry i ≥ FWD_MIN yields fwd_sel = i+1 instead of a hazard; the youngest (lowest i) match wins.
  - A match in entry i < FWD_MIN still stalls.
  - fwd_sel = 0 means the register file value.
- When undefined: no forwarding ports, and every match stalls as above.

Test Plan:
- Reset mid-run with 3 valid entries, rstn low -> stage_valid=0, wb_valid=0, stall_cnt=0 immediately, before the next edge.
- Issue "addi x5" then "add x6,x5,x1" back-to-back, DEPTH=4, RF_BYPASS=1, no FWD -> stall_id high for 3 cycles; second instruction issues on the 4th cycle; stall_cnt=3.
- Instruction with rd=x0 followed by a reader of x0 -> no stall; wb_valid=0 when it reaches entry 3.
- flush_req together with a hazarding decode instruction, FLUSH_DEPTH=1 -> issue=0, stall_id=0, entry 0 invalid after the edge; the older entry moves to entry 1.
- ext_stall high for 5 cycles with a hazard present -> entries frozen, stall_cnt unchanged; after release the hazard countdown resumes.
- FWD_HAZARD_EN, FWD_MIN=1: producer in entry 1 matching rs2 -> no stall, fwd_sel_rs2=2. Producer in entry 0 -> 1-cycle stall, then fwd_sel_rs2=2.
